// File: rtl/tiny_cpu_pkg.sv
// Shared widths, instruction field encodings and ALU operation codes
// for the tiny 5-bit accumulator core.
package tiny_cpu_pkg;

  localparam int DW = 5;
  localparam int IW = 6;
  localparam int NREGS = 4;

  localparam logic [1:0] MAJ_LDI = 2'b00;
  localparam logic [1:0] MAJ_ALU = 2'b01;
  localparam logic [1:0] MAJ_REG = 2'b10;
  localparam logic [1:0] MAJ_SYS = 2'b11;

  localparam logic [1:0] REG_ST   = 2'b00;
  localparam logic [1:0] REG_LD   = 2'b01;
  localparam logic [1:0] REG_SWP  = 2'b10;
  localparam logic [1:0] REG_OUTR = 2'b11;

  localparam logic [1:0] SYS_JMP   = 2'b00;
  localparam logic [1:0] SYS_OUT   = 2'b01;
  localparam logic [1:0] SYS_UNARY = 2'b10;
  localparam logic [1:0] SYS_NOP   = 2'b11;

  localparam logic [1:0] CC_ALWAYS = 2'b00;
  localparam logic [1:0] CC_ZERO   = 2'b01;
  localparam logic [1:0] CC_NZERO  = 2'b10;
  localparam logic [1:0] CC_CARRY  = 2'b11;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_XOR = 3'd3,
    ALU_SHL = 3'd4,
    ALU_SHR = 3'd5,
    ALU_NOT = 3'd6,
    ALU_INC = 3'd7
  } alu_op_e;

endpackage

// File: rtl/tiny_cpu_alu.sv
// Combinational datapath: computes the new accumulator and carry for
// every binary and unary arithmetic/logic operation.
module tiny_cpu_alu
  import tiny_cpu_pkg::*;
(
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] operand,
  input  logic [2:0]    op,
  input  logic          c_in,
  output logic [DW-1:0] result,
  output logic          c_out
);

  logic [DW:0] wide;

  always_comb begin
    wide   = '0;
    result = acc;
    c_out  = c_in;
    case (alu_op_e'(op))
      ALU_ADD: begin
        wide   = {1'b0, acc} + {1'b0, operand};
        result = wide[DW-1:0];
        c_out  = wide[DW];
      end
      ALU_SUB: begin
        result = acc - operand;
        c_out  = (acc < operand);
      end
      ALU_AND: result = acc & operand;
      ALU_XOR: result = acc ^ operand;
      ALU_SHL: begin
        result = {acc[DW-2:0], 1'b0};
        c_out  = acc[DW-1];
      end
      ALU_SHR: begin
        result = {1'b0, acc[DW-1:1]};
        c_out  = acc[0];
      end
      ALU_NOT: result = ~acc;
      ALU_INC: begin
        wide   = {1'b0, acc} + {{DW{1'b0}}, 1'b1};
        result = wide[DW-1:0];
        c_out  = wide[DW];
      end
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/tiny_cpu_top.sv
// Accumulator core: decodes one externally supplied instruction per clock
// and updates ACC, carry, four registers, the output port and jump flag.
module tiny_cpu_top
  import tiny_cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr,
  output logic [DW-1:0] io_out,
  output logic          cjump
);

  logic [DW-1:0]            acc_q, acc_d;
  logic                     c_q, c_d;
  logic [NREGS-1:0][DW-1:0] rf_q, rf_d;
  logic [DW-1:0]            io_out_q, io_out_d;
  logic                     cjump_q, cjump_d;

  logic [1:0]    major, op, sel;
  logic [DW-1:0] operand;
  alu_op_e       alu_op;
  logic [DW-1:0] alu_result;
  logic          alu_c;

  assign major   = instr[5:4];
  assign op      = instr[3:2];
  assign sel     = instr[1:0];
  assign operand = rf_q[sel];

  // Binary ops come from the ALU major; unary ops live in the system major.
  always_comb begin
    alu_op = ALU_ADD;
    if (major == MAJ_ALU) begin
      alu_op = alu_op_e'({1'b0, op});
    end else if (major == MAJ_SYS && op == SYS_UNARY) begin
      alu_op = alu_op_e'({1'b1, sel});
    end
  end

  tiny_cpu_alu u_alu (
    .acc     (acc_q),
    .operand (operand),
    .op      (alu_op),
    .c_in    (c_q),
    .result  (alu_result),
    .c_out   (alu_c)
  );

  always_comb begin
    acc_d    = acc_q;
    c_d      = c_q;
    rf_d     = rf_q;
    io_out_d = io_out_q;
    cjump_d  = 1'b0;
    case (major)
      MAJ_LDI: acc_d = {1'b0, instr[3:0]};
      MAJ_ALU: begin
        acc_d = alu_result;
        c_d   = alu_c;
      end
      MAJ_REG: begin
        case (op)
          REG_ST:   rf_d[sel] = acc_q;
          REG_LD:   acc_d = operand;
          REG_SWP: begin
            acc_d     = operand;
            rf_d[sel] = acc_q;
          end
          default:  io_out_d = operand;
        endcase
      end
      default: begin
        case (op)
          SYS_JMP: begin
            case (sel)
              CC_ALWAYS: cjump_d = 1'b1;
              CC_ZERO:   cjump_d = (acc_q == '0);
              CC_NZERO:  cjump_d = (acc_q != '0);
              default:   cjump_d = c_q;
            endcase
          end
          SYS_OUT:   io_out_d = acc_q;
          SYS_UNARY: begin
            acc_d = alu_result;
            c_d   = alu_c;
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      c_q      <= 1'b0;
      rf_q     <= '0;
      io_out_q <= '0;
      cjump_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      c_q      <= c_d;
      rf_q     <= rf_d;
      io_out_q <= io_out_d;
      cjump_q  <= cjump_d;
    end
  end

  assign io_out = io_out_q;
  assign cjump  = cjump_q;

endmodule

// File: tb/tb_tiny_cpu_top.sv
// Directed scenarios plus a random instruction stream checked against an
// integer-arithmetic model of the accumulator machine.
module tb_tiny_cpu_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] instr = 6'b111100;
  logic [4:0] io_out;
  logic       cjump;

  int checks   = 0;
  int failures = 0;

  int m_acc, m_c, m_io, m_cj;
  int m_r[4];

  localparam logic [5:0] NOP = 6'b111100;
  localparam logic [5:0] OUT = 6'b110100;

  tiny_cpu_top dut (
    .clk    (clk),
    .rst    (rst),
    .instr  (instr),
    .io_out (io_out),
    .cjump  (cjump)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ldi(input int n);
    return {2'b00, 4'(n)};
  endfunction
  function automatic logic [5:0] alu(input int o, input int r);
    return {2'b01, 2'(o), 2'(r)};
  endfunction
  function automatic logic [5:0] regop(input int o, input int r);
    return {2'b10, 2'(o), 2'(r)};
  endfunction
  function automatic logic [5:0] jmp(input int cc);
    return {4'b1100, 2'(cc)};
  endfunction
  function automatic logic [5:0] unary(input int s);
    return {4'b1110, 2'(s)};
  endfunction

  function void model_reset();
    m_acc = 0; m_c = 0; m_io = 0; m_cj = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
  endfunction

  function void model_step(input logic [5:0] ins);
    int maj, o, s, v, t, cj;
    maj = int'(ins[5:4]);
    o   = int'(ins[3:2]);
    s   = int'(ins[1:0]);
    v   = m_r[s];
    cj  = 0;
    case (maj)
      0: m_acc = int'(ins[3:0]);
      1: case (o)
           0: begin t = m_acc + v; m_c = (t > 31) ? 1 : 0; m_acc = t % 32; end
           1: begin m_c = (m_acc < v) ? 1 : 0; m_acc = (m_acc - v + 32) % 32; end
           2: m_acc = m_acc & v;
           default: m_acc = m_acc ^ v;
         endcase
      2: case (o)
           0: m_r[s] = m_acc;
           1: m_acc = v;
           2: begin t = m_acc; m_acc = v; m_r[s] = t; end
           default: m_io = v;
         endcase
      default: case (o)
           0: case (s)
                0: cj = 1;
                1: cj = (m_acc == 0) ? 1 : 0;
                2: cj = (m_acc != 0) ? 1 : 0;
                default: cj = m_c;
              endcase
           1: m_io = m_acc;
           2: case (s)
                0: begin t = m_acc * 2; m_c = (t >= 32) ? 1 : 0; m_acc = t % 32; end
                1: begin m_c = m_acc % 2; m_acc = m_acc / 2; end
                2: m_acc = 31 - m_acc;
                default: begin t = m_acc + 1; m_c = (t > 31) ? 1 : 0; m_acc = t % 32; end
              endcase
           default: ;
         endcase
    endcase
    m_cj = cj;
  endfunction

  task automatic do_instr(input logic [5:0] ins);
    @(negedge clk);
    rst   = 1'b0;
    instr = ins;
    @(posedge clk);
    #1;
    model_step(ins);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst   = 1'b1;
    instr = 6'($urandom);
    repeat (n) @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(2);
    do_instr(NOP);
    checks++;
    if (io_out !== 5'd0) begin failures++; $display("[TB] FAIL reset_io io_out=%0d expected=0", io_out); end
    checks++;
    if (cjump !== 1'b0) begin failures++; $display("[TB] FAIL reset_cjump cjump=%0b expected=0", cjump); end
    do_instr(OUT);
    checks++;
    if (io_out !== 5'd0) begin failures++; $display("[TB] FAIL reset_out io_out=%0d expected=0", io_out); end
    do_instr(jmp(1));
    checks++;
    if (cjump !== 1'b1) begin failures++; $display("[TB] FAIL reset_jz cjump=%0b expected=1", cjump); end
  endtask

  task automatic test_add();
    do_instr(ldi(5));
    do_instr(regop(0, 1));
    do_instr(ldi(3));
    do_instr(alu(0, 1));
    do_instr(OUT);
    checks++;
    if (io_out !== 5'd8) begin failures++; $display("[TB] FAIL add_out io_out=%0d expected=8", io_out); end
    do_instr(jmp(3));
    checks++;
    if (cjump !== 1'b0) begin failures++; $display("[TB] FAIL add_carry cjump=%0b expected=0", cjump); end
  endtask

  task automatic test_carry();
    do_instr(ldi(15));
    do_instr(unary(3));
    do_instr(unary(0));
    do_instr(jmp(3));
    checks++;
    if (cjump !== 1'b1) begin failures++; $display("[TB] FAIL shl_carry cjump=%0b expected=1", cjump); end
    do_instr(jmp(1));
    checks++;
    if (cjump !== 1'b1) begin failures++; $display("[TB] FAIL back_to_back cjump=%0b expected=1", cjump); end
    do_instr(NOP);
    checks++;
    if (cjump !== 1'b0) begin failures++; $display("[TB] FAIL pulse_clear cjump=%0b expected=0", cjump); end
    do_instr(OUT);
    checks++;
    if (io_out !== 5'd0) begin failures++; $display("[TB] FAIL shl_acc io_out=%0d expected=0", io_out); end
  endtask

  task automatic test_sub();
    do_instr(ldi(0));
    do_instr(alu(1, 0));
    do_instr(jmp(2));
    checks++;
    if (cjump !== 1'b0) begin failures++; $display("[TB] FAIL sub_jnz cjump=%0b expected=0", cjump); end
    do_instr(jmp(1));
    checks++;
    if (cjump !== 1'b1) begin failures++; $display("[TB] FAIL sub_jz cjump=%0b expected=1", cjump); end
    do_instr(ldi(1));
    do_instr(regop(0, 3));
    do_instr(ldi(0));
    do_instr(alu(1, 3));
    do_instr(OUT);
    checks++;
    if (io_out !== 5'd31) begin failures++; $display("[TB] FAIL borrow_acc io_out=%0d expected=31", io_out); end
    do_instr(jmp(3));
    checks++;
    if (cjump !== 1'b1) begin failures++; $display("[TB] FAIL borrow_c cjump=%0b expected=1", cjump); end
  endtask

  task automatic test_swap();
    do_instr(ldi(9));
    do_instr(regop(0, 2));
    do_instr(ldi(6));
    do_instr(regop(2, 2));
    do_instr(OUT);
    checks++;
    if (io_out !== 5'd9) begin failures++; $display("[TB] FAIL swp_acc io_out=%0d expected=9", io_out); end
    do_instr(regop(3, 2));
    checks++;
    if (io_out !== 5'd6) begin failures++; $display("[TB] FAIL swp_reg io_out=%0d expected=6", io_out); end
    do_instr(unary(2));
    do_instr(OUT);
    checks++;
    if (io_out !== 5'd22) begin failures++; $display("[TB] FAIL not_acc io_out=%0d expected=22", io_out); end
  endtask

  task automatic test_random();
    logic [5:0] ins;
    do_reset(1);
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        do_reset(1);
        do_instr(NOP);
        checks++;
        if (io_out !== 5'd0 || cjump !== 1'b0) begin
          failures++;
          $display("[TB] FAIL mid_reset io_out=%0d cjump=%0b expected=0/0", io_out, cjump);
        end
      end
      ins = ($urandom_range(3) == 0) ? OUT : 6'($urandom);
      do_instr(ins);
      checks++;
      if (io_out !== 5'(m_io) || cjump !== 1'(m_cj)) begin
        failures++;
        $display("[TB] FAIL random step=%0d instr=%b io_out=%0d cjump=%0b expected=%0d/%0d",
                 i, ins, io_out, cjump, m_io, m_cj);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_swap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
